// File: rtl/banco_ctrl_pkg.sv
// banco_ctrl_pkg: shared types, constants and helpers for the register-bank
// command controller (banco_registros_ctrl).
//   op_e       command opcodes
//   state_e    controller FSM states
//   wr_beat_t  size/half/word triple that describes one bank write
package banco_ctrl_pkg;

    typedef enum logic [1:0] {
        OpLoadImm = 2'd0,
        OpMove    = 2'd1,
        OpRead    = 2'd2,
        OpRsvd    = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        StIdle,
        StRdWait,
        StWrite,
        StResp,
        StCheck
    } state_e;

    localparam logic RwRead  = 1'b0;
    localparam logic RwWrite = 1'b1;
    localparam logic Size8   = 1'b0;
    localparam logic Size16  = 1'b1;

    typedef struct packed {
        logic        size;
        logic        hl;
        logic [15:0] word;
    } wr_beat_t;

    function automatic logic [7:0] pick_byte(input logic [15:0] w, input logic hi);
        return hi ? w[15:8] : w[7:0];
    endfunction

    // A byte write always goes out zero-extended, and the half select is only
    // meaningful for 8-bit accesses.
    function automatic wr_beat_t mk_write(input logic sz, input logic hl, input logic [15:0] val);
        wr_beat_t b;
        b.size = sz;
        b.hl   = (sz == Size16) ? 1'b0 : hl;
        b.word = (sz == Size16) ? val : {8'h00, val[7:0]};
        return b;
    endfunction

endpackage

// File: rtl/banco_registros_ctrl_if.sv
// banco_registros_ctrl_if: command/response handshake bundle between the
// decode/sequencing logic (master) and the bank controller (slave).
//   cmd_*  command channel, valid/ready
//   rsp_*  response channel, valid/ready, with data and error flag
interface banco_registros_ctrl_if;

    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [2:0]  cmd_dst;
    logic [2:0]  cmd_src;
    logic        cmd_size;
    logic        cmd_dst_hl;
    logic        cmd_src_hl;
    logic [15:0] cmd_imm;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_data;
    logic        rsp_err;

    modport master (
        output cmd_valid, cmd_op, cmd_dst, cmd_src, cmd_size, cmd_dst_hl, cmd_src_hl, cmd_imm,
        output rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_dst, cmd_src, cmd_size, cmd_dst_hl, cmd_src_hl, cmd_imm,
        input  rsp_ready,
        output cmd_ready, rsp_valid, rsp_data, rsp_err
    );

endinterface

// File: rtl/banco_ctrl_lat_cnt.sv
// banco_ctrl_lat_cnt: load/decrement counter timing a bank read window.
//   clk_i, rst_ni  clock, async active-low reset
//   load_i         load load_val_i (takes priority over decrement)
//   load_val_i     cycles remaining after the load cycle
//   done_o         count has reached zero (last cycle of the window)
module banco_ctrl_lat_cnt #(
    parameter int unsigned CntW = 1
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            load_i,
    input  logic [CntW-1:0] load_val_i,
    output logic            done_o
);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CntW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == '0);

endmodule

// File: rtl/banco_registros_ctrl.sv
// banco_registros_ctrl: command-driven initiator for the 8x16-bit register bank.
// Turns LOAD_IMM / MOVE / READ commands into registered bank read/write cycles,
// handling byte extraction/insertion, and returns one response per command.
//   clk, reset         clock, async active-low reset
//   bus (slave)        command/response handshake
//   select_reg, size, select_high_low, select_data_h_reg, read_write, data
//                      registered bank control/write-data outputs
//   bank_rdata         bank read data, valid RD_LAT cycles after address
// Optional: define BANCO_CTRL_WRITE_CHECK_EN to re-read and verify every write.
module banco_registros_ctrl
    import banco_ctrl_pkg::*;
#(
    parameter int unsigned RD_LAT    = 1,
    parameter int unsigned NREG      = 8,
    parameter int unsigned BYTE_REGS = 4,
    localparam int unsigned SelW     = $clog2(NREG)
) (
    input  logic                 clk,
    input  logic                 reset,
    banco_registros_ctrl_if.slave bus,
    output logic [SelW-1:0]      select_reg,
    output logic                 size,
    output logic                 select_high_low,
    output logic                 select_data_h_reg,
    output logic                 read_write,
    output logic [15:0]          data,
    input  logic [15:0]          bank_rdata
);

    // Wide enough to hold RD_LAT (check window is one cycle longer than a read).
    localparam int unsigned CntW       = $clog2(RD_LAT + 1);
    localparam logic [CntW-1:0] RdLoad = CntW'(RD_LAT - 1);
    localparam logic [SelW:0] ByteLim  = (SelW + 1)'(BYTE_REGS);

    state_e          state_q, state_d;
    op_e             op_q, op_d;
    logic [SelW-1:0] dst_q, dst_d;
    logic            size_q, size_d;
    logic            dst_hl_q, dst_hl_d;
    logic            src_hl_q, src_hl_d;

    logic            cmd_ready_q, cmd_ready_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [15:0]     rsp_data_q, rsp_data_d;
    logic            rsp_err_q, rsp_err_d;

    logic [SelW-1:0] sel_q, sel_d;
    logic            bank_size_q, bank_size_d;
    logic            shl_q, shl_d;
    logic            sdh_q, sdh_d;
    logic            rw_q, rw_d;
    logic [15:0]     wdata_q, wdata_d;

    logic            cnt_load;
    logic [CntW-1:0] cnt_val;
    logic            cnt_done;

    op_e             in_op;
    logic [SelW-1:0] in_dst, in_src;
    logic            in_illegal;
    logic [15:0]     rd_val;
    wr_beat_t        beat;

    assign in_op  = op_e'(bus.cmd_op);
    assign in_dst = bus.cmd_dst[SelW-1:0];
    assign in_src = bus.cmd_src[SelW-1:0];

    // Byte ops may only touch the byte-addressable low registers; READ has no
    // destination and LOAD_IMM has no source.
    assign in_illegal = (in_op == OpRsvd)
        || ((bus.cmd_size == Size8) && (in_op != OpRead) && ({1'b0, in_dst} >= ByteLim))
        || ((bus.cmd_size == Size8) && (in_op != OpLoadImm) && ({1'b0, in_src} >= ByteLim));

    assign rd_val = (size_q == Size16) ? bank_rdata : {8'h00, pick_byte(bank_rdata, src_hl_q)};

`ifdef BANCO_CTRL_WRITE_CHECK_EN
    // One extra cycle so the re-read window starts after the write has landed.
    localparam logic [CntW-1:0] ChkLoad = CntW'(RD_LAT);
    logic chk_mismatch;
    assign chk_mismatch = (size_q == Size16) ? (bank_rdata != wdata_q)
                                             : (pick_byte(bank_rdata, dst_hl_q) != wdata_q[7:0]);
`endif

    banco_ctrl_lat_cnt #(
        .CntW (CntW)
    ) u_lat_cnt (
        .clk_i      (clk),
        .rst_ni     (reset),
        .load_i     (cnt_load),
        .load_val_i (cnt_val),
        .done_o     (cnt_done)
    );

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        dst_d       = dst_q;
        size_d      = size_q;
        dst_hl_d    = dst_hl_q;
        src_hl_d    = src_hl_q;
        cmd_ready_d = cmd_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        sel_d       = sel_q;
        bank_size_d = bank_size_q;
        shl_d       = shl_q;
        sdh_d       = sdh_q;
        wdata_d     = wdata_q;
        rw_d        = RwRead;
        cnt_load    = 1'b0;
        cnt_val     = '0;
        beat        = mk_write(Size16, 1'b0, 16'h0000);

        case (state_q)
            StIdle: begin
                if (bus.cmd_valid && cmd_ready_q) begin
                    op_d        = in_op;
                    dst_d       = in_dst;
                    size_d      = bus.cmd_size;
                    dst_hl_d    = bus.cmd_dst_hl;
                    src_hl_d    = bus.cmd_src_hl;
                    cmd_ready_d = 1'b0;
                    rsp_err_d   = 1'b0;
                    rsp_data_d  = '0;
                    if (in_illegal) begin
                        state_d     = StResp;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end else if (in_op == OpLoadImm) begin
                        beat        = mk_write(bus.cmd_size, bus.cmd_dst_hl, bus.cmd_imm);
                        state_d     = StWrite;
                        sel_d       = in_dst;
                        bank_size_d = beat.size;
                        shl_d       = beat.hl;
                        sdh_d       = beat.hl;
                        wdata_d     = beat.word;
                        rw_d        = RwWrite;
                        rsp_data_d  = beat.word;
                    end else begin
                        state_d     = StRdWait;
                        sel_d       = in_src;
                        bank_size_d = Size16;
                        cnt_load    = 1'b1;
                        cnt_val     = RdLoad;
                    end
                end
            end

            StRdWait: begin
                if (cnt_done) begin
                    if (op_q == OpMove) begin
                        beat        = mk_write(size_q, dst_hl_q, rd_val);
                        state_d     = StWrite;
                        sel_d       = dst_q;
                        bank_size_d = beat.size;
                        shl_d       = beat.hl;
                        sdh_d       = beat.hl;
                        wdata_d     = beat.word;
                        rw_d        = RwWrite;
                        rsp_data_d  = beat.word;
                    end else begin
                        state_d     = StResp;
                        rsp_valid_d = 1'b1;
                        rsp_data_d  = rd_val;
                    end
                end
            end

            StWrite: begin
`ifdef BANCO_CTRL_WRITE_CHECK_EN
                state_d     = StCheck;
                sel_d       = dst_q;
                bank_size_d = Size16;
                cnt_load    = 1'b1;
                cnt_val     = ChkLoad;
`else
                state_d     = StResp;
                rsp_valid_d = 1'b1;
`endif
            end

`ifdef BANCO_CTRL_WRITE_CHECK_EN
            StCheck: begin
                if (cnt_done) begin
                    state_d     = StResp;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = chk_mismatch;
                end
            end
`endif

            StResp: begin
                if (bus.rsp_ready) begin
                    state_d     = StIdle;
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                end
            end

            default: begin
                state_d     = StIdle;
                rsp_valid_d = 1'b0;
                cmd_ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            op_q        <= OpLoadImm;
            dst_q       <= '0;
            size_q      <= 1'b0;
            dst_hl_q    <= 1'b0;
            src_hl_q    <= 1'b0;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            sel_q       <= '0;
            bank_size_q <= 1'b0;
            shl_q       <= 1'b0;
            sdh_q       <= 1'b0;
            rw_q        <= RwRead;
            wdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            dst_q       <= dst_d;
            size_q      <= size_d;
            dst_hl_q    <= dst_hl_d;
            src_hl_q    <= src_hl_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            sel_q       <= sel_d;
            bank_size_q <= bank_size_d;
            shl_q       <= shl_d;
            sdh_q       <= sdh_d;
            rw_q        <= rw_d;
            wdata_q     <= wdata_d;
        end
    end

    assign bus.cmd_ready     = cmd_ready_q;
    assign bus.rsp_valid     = rsp_valid_q;
    assign bus.rsp_data      = rsp_data_q;
    assign bus.rsp_err       = rsp_err_q;
    assign select_reg        = sel_q;
    assign size              = bank_size_q;
    assign select_high_low   = shl_q;
    assign select_data_h_reg = sdh_q;
    assign read_write        = rw_q;
    assign data              = wdata_q;

endmodule

// File: tb/tb_banco_registros_ctrl.sv
// Testbench for banco_registros_ctrl (RD_LAT=2) with a behavioural bank model.
module tb_banco_registros_ctrl;

    localparam int unsigned RdLat = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [2:0]  select_reg;
    logic        size;
    logic        select_high_low;
    logic        select_data_h_reg;
    logic        read_write;
    logic [15:0] data;
    logic [15:0] bank_rdata = 16'h0000;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    banco_registros_ctrl_if bus();

    banco_registros_ctrl #(
        .RD_LAT    (RdLat),
        .NREG      (8),
        .BYTE_REGS (4)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .bus               (bus),
        .select_reg        (select_reg),
        .size              (size),
        .select_high_low   (select_high_low),
        .select_data_h_reg (select_data_h_reg),
        .read_write        (read_write),
        .data              (data),
        .bank_rdata        (bank_rdata)
    );

    // Bank model: registered read (2-cycle latency from address), byte writes by half.
    logic [15:0] regs [8] = '{default: 16'h0000};
    int bank_writes = 0;

    always @(posedge clk) begin
        bank_rdata <= regs[select_reg];
        if (read_write) begin
            bank_writes <= bank_writes + 1;
            if (size) regs[select_reg] <= data;
            else if (select_high_low) regs[select_reg][15:8] <= data[7:0];
            else regs[select_reg][7:0] <= data[7:0];
        end
    end

    typedef struct {
        logic [1:0]  op;
        logic [2:0]  dst;
        logic [2:0]  src;
        logic        sz;
        logic        dhl;
        logic        shl;
        logic [15:0] imm;
        logic [15:0] e_data;
        logic        e_err;
        int          e_lat;
        logic        e_wr;
        logic [2:0]  e_sel;
        logic        e_size;
        logic        e_hl;
    } vec_t;

    vec_t vecs[18];

    logic [2:0]  w_sel;
    logic        w_size;
    logic        w_shl;
    logic        w_sdh;
    logic [15:0] w_data;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_cmd(input vec_t v);
        bus.cmd_op     = v.op;
        bus.cmd_dst    = v.dst;
        bus.cmd_src    = v.src;
        bus.cmd_size   = v.sz;
        bus.cmd_dst_hl = v.dhl;
        bus.cmd_src_hl = v.shl;
        bus.cmd_imm    = v.imm;
        bus.cmd_valid  = 1'b1;
    endtask

    // Called at a negedge; returns just after the accepting posedge.
    task automatic wait_accept(input string name);
        int n = 0;
        while (!bus.cmd_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({name, " accept"}, 32'(n < 40), 32'd1);
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
    endtask

    // lat counts cycles after the accept cycle until rsp_valid is seen.
    task automatic watch_rsp(output int lat, output int nwr);
        lat = 0;
        nwr = 0;
        while (lat < 30) begin
            @(negedge clk);
            lat++;
            if (read_write) begin
                nwr++;
                w_sel  = select_reg;
                w_size = size;
                w_shl  = select_high_low;
                w_sdh  = select_data_h_reg;
                w_data = data;
            end
            if (bus.rsp_valid) break;
        end
    endtask

    task automatic ack_rsp();
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int nwr;
        int wb;
        vec_t v;

        //            op dst src sz dhl shl imm       e_data    err lat wr sel size hl
        vecs[0]  = '{2'd0, 3'd2, 3'd0, 1, 0, 0, 16'hBEEF, 16'hBEEF, 0, 2, 1, 3'd2, 1, 0};
        vecs[1]  = '{2'd2, 3'd0, 3'd2, 1, 0, 0, 16'h0000, 16'hBEEF, 0, 3, 0, 3'd0, 0, 0};
        vecs[2]  = '{2'd0, 3'd1, 3'd0, 0, 1, 0, 16'h12A5, 16'h00A5, 0, 2, 1, 3'd1, 0, 1};
        vecs[3]  = '{2'd2, 3'd0, 3'd1, 0, 0, 1, 16'h0000, 16'h00A5, 0, 3, 0, 3'd0, 0, 0};
        vecs[4]  = '{2'd2, 3'd0, 3'd1, 1, 0, 0, 16'h0000, 16'hA500, 0, 3, 0, 3'd0, 0, 0};
        vecs[5]  = '{2'd0, 3'd0, 3'd0, 1, 0, 0, 16'h7F01, 16'h7F01, 0, 2, 1, 3'd0, 1, 0};
        vecs[6]  = '{2'd1, 3'd3, 3'd0, 0, 0, 1, 16'h0000, 16'h007F, 0, 4, 1, 3'd3, 0, 0};
        vecs[7]  = '{2'd2, 3'd0, 3'd3, 1, 0, 0, 16'h0000, 16'h007F, 0, 3, 0, 3'd0, 0, 0};
        vecs[8]  = '{2'd1, 3'd6, 3'd2, 1, 0, 0, 16'h0000, 16'hBEEF, 0, 4, 1, 3'd6, 1, 0};
        vecs[9]  = '{2'd2, 3'd0, 3'd6, 1, 0, 0, 16'h0000, 16'hBEEF, 0, 3, 0, 3'd0, 0, 0};
        vecs[10] = '{2'd0, 3'd5, 3'd0, 0, 0, 0, 16'h1234, 16'h0000, 1, 1, 0, 3'd0, 0, 0};
        vecs[11] = '{2'd3, 3'd0, 3'd0, 1, 0, 0, 16'h5555, 16'h0000, 1, 1, 0, 3'd0, 0, 0};
        vecs[12] = '{2'd1, 3'd0, 3'd5, 0, 0, 0, 16'h0000, 16'h0000, 1, 1, 0, 3'd0, 0, 0};
        vecs[13] = '{2'd2, 3'd0, 3'd7, 0, 0, 0, 16'h0000, 16'h0000, 1, 1, 0, 3'd0, 0, 0};
        vecs[14] = '{2'd2, 3'd7, 3'd0, 0, 0, 0, 16'h0000, 16'h0001, 0, 3, 0, 3'd0, 0, 0};
        vecs[15] = '{2'd1, 3'd3, 3'd3, 1, 0, 0, 16'h0000, 16'h007F, 0, 4, 1, 3'd3, 1, 0};
        vecs[16] = '{2'd1, 3'd0, 3'd2, 0, 1, 0, 16'h0000, 16'h00EF, 0, 4, 1, 3'd0, 0, 1};
        vecs[17] = '{2'd2, 3'd0, 3'd0, 1, 0, 0, 16'h0000, 16'hEF01, 0, 3, 0, 3'd0, 0, 0};

        bus.cmd_valid  = 1'b0;
        bus.cmd_op     = 2'd0;
        bus.cmd_dst    = 3'd0;
        bus.cmd_src    = 3'd0;
        bus.cmd_size   = 1'b0;
        bus.cmd_dst_hl = 1'b0;
        bus.cmd_src_hl = 1'b0;
        bus.cmd_imm    = 16'h0000;
        bus.rsp_ready  = 1'b0;

        // Reset state
        #12;
        chk("reset cmd_ready", 32'(bus.cmd_ready), 32'd1);
        chk("reset rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("reset read_write", 32'(read_write), 32'd0);
        chk("reset select_reg", 32'(select_reg), 32'd0);
        chk("reset data", 32'(data), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 18; i++) begin
            drive_cmd(vecs[i]);
            wait_accept($sformatf("v%0d", i));
            watch_rsp(lat, nwr);
            chk($sformatf("v%0d latency", i), 32'(lat), 32'(vecs[i].e_lat));
            chk($sformatf("v%0d rsp_data", i), 32'(bus.rsp_data), 32'(vecs[i].e_data));
            chk($sformatf("v%0d rsp_err", i), 32'(bus.rsp_err), 32'(vecs[i].e_err));
            chk($sformatf("v%0d cmd_ready in resp", i), 32'(bus.cmd_ready), 32'd0);
            chk($sformatf("v%0d write count", i), 32'(nwr), 32'(vecs[i].e_wr));
            if (vecs[i].e_wr && nwr == 1) begin
                chk($sformatf("v%0d wr select_reg", i), 32'(w_sel), 32'(vecs[i].e_sel));
                chk($sformatf("v%0d wr size", i), 32'(w_size), 32'(vecs[i].e_size));
                chk($sformatf("v%0d wr select_high_low", i), 32'(w_shl), 32'(vecs[i].e_hl));
                chk($sformatf("v%0d wr select_data_h_reg", i), 32'(w_sdh), 32'(vecs[i].e_hl));
                chk($sformatf("v%0d wr data", i), 32'(w_data), 32'(vecs[i].e_data));
            end
            ack_rsp();
        end

        // Response backpressure with a command offered while the response is pending
        v = '{2'd0, 3'd4, 3'd0, 1, 0, 0, 16'h1234, 16'h1234, 0, 2, 1, 3'd4, 1, 0};
        drive_cmd(v);
        wait_accept("bp load");
        watch_rsp(lat, nwr);
        chk("bp load latency", 32'(lat), 32'd2);
        v = '{2'd2, 3'd0, 3'd4, 1, 0, 0, 16'h0000, 16'h1234, 0, 3, 0, 3'd0, 0, 0};
        drive_cmd(v);
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("bp c%0d rsp_valid", k), 32'(bus.rsp_valid), 32'd1);
            chk($sformatf("bp c%0d rsp_data", k), 32'(bus.rsp_data), 32'h1234);
            chk($sformatf("bp c%0d cmd_ready", k), 32'(bus.cmd_ready), 32'd0);
            @(negedge clk);
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
        @(negedge clk);
        chk("bp after ack cmd_ready", 32'(bus.cmd_ready), 32'd1);
        chk("bp after ack rsp_valid", 32'(bus.rsp_valid), 32'd0);
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        watch_rsp(lat, nwr);
        chk("bp read latency", 32'(lat), 32'd3);
        chk("bp read rsp_data", 32'(bus.rsp_data), 32'h1234);
        ack_rsp();

        // Reset during RD_WAIT of a MOVE
        v = '{2'd1, 3'd7, 3'd2, 1, 0, 0, 16'h0000, 16'hBEEF, 0, 4, 1, 3'd7, 1, 0};
        drive_cmd(v);
        wait_accept("rst move");
        wb = bank_writes;
        #2;
        reset = 1'b0;
        #1;
        chk("rst cmd_ready", 32'(bus.cmd_ready), 32'd1);
        chk("rst rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst rsp_data", 32'(bus.rsp_data), 32'd0);
        chk("rst read_write", 32'(read_write), 32'd0);
        chk("rst select_reg", 32'(select_reg), 32'd0);
        chk("rst data", 32'(data), 32'd0);
        chk("rst size", 32'(size), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (6) @(negedge clk);
        chk("rst no bank write", 32'(bank_writes), 32'(wb));
        chk("rst reg7 untouched", 32'(regs[7]), 32'd0);
        chk("rst release cmd_ready", 32'(bus.cmd_ready), 32'd1);
        chk("rst release rsp_valid", 32'(bus.rsp_valid), 32'd0);

        v = '{2'd2, 3'd0, 3'd2, 1, 0, 0, 16'h0000, 16'hBEEF, 0, 3, 0, 3'd0, 0, 0};
        drive_cmd(v);
        wait_accept("post rst read");
        watch_rsp(lat, nwr);
        chk("post rst latency", 32'(lat), 32'd3);
        chk("post rst rsp_data", 32'(bus.rsp_data), 32'hBEEF);
        ack_rsp();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/banco_registros_ctrl.md
Name: banco_registros_ctrl

Overview:
- Command-driven initiator for the 8×16-bit register bank (Banco_de_Registros); sits between the decode/sequencing logic and the bank's control port.
- Converts high-level register commands (load immediate, register move, register read) into the bank's cycle-level signalling.
- Performs byte extraction and insertion for 8-bit operations; returns a response per command.

Parameters:
- RD_LAT, 1, cycles from bank read-address presentation to valid bank_rdata (1..4).
- NREG, 8, number of bank registers (select width = $clog2(NREG)).
- BYTE_REGS, 4, registers 0..BYTE_REGS-1 are byte-addressable (low/high halves).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  controller can accept a command
- cmd_op  input  2  0=LOAD_IMM, 1=MOVE, 2=READ, 3=reserved
- cmd_dst  input  3  destination register
- cmd_src  input  3  source register (MOVE/READ)
- cmd_size  input  1  1=16-bit, 0=8-bit
- cmd_dst_hl  input  1  8-bit destination half: 0=low, 1=high
- cmd_src_hl  input  1  8-bit source half: 0=low, 1=high
- cmd_imm  input  16  immediate value (LOAD_IMM)
- rsp_valid  output  1  response present
- rsp_ready  input  1  response consumed
- rsp_data  output  16  read value, or value written
- rsp_err  output  1  command rejected
- select_reg  output  3  bank register select
- size  output  1  bank access size
- select_high_low  output  1  bank byte half
- select_data_h_reg  output  1  bank high-part data select
- read_write  output  1  0=read, 1=write (bank write strobe)
- data  output  16  bank write data
- bank_rdata  input  16  bank read data

Behaviour:
- Reset:
  - All outputs 0 except cmd_ready=1.
  - State=IDLE.
  - Reset asserted mid-command aborts the command immediately; any pending response is dropped; no bank write completes after reset assertion.
- FSM states: IDLE, RD_WAIT, WRITE, RESP.
  - IDLE:
    - cmd_ready=1.
    - A handshake (cmd_valid&cmd_ready at posedge) latches all cmd_* fields.
    - LOAD_IMM→WRITE.
    - MOVE/READ→RD_WAIT.
    - Illegal command→RESP with rsp_err=1 and no bank access.
    - cmd_ready=0 in every other state.
  - RD_WAIT:
    - Drives select_reg=src, size=1, read_write=0 for RD_LAT cycles.
    - bank_rdata is sampled on the last cycle.
    - MOVE→WRITE; READ→RESP.
  - WRITE: asserts read_write=1 for exactly one cycle with select_reg=dst, then →RESP.
  - RESP:
    - rsp_valid=1, with rsp_data/rsp_err held stable until rsp_valid&rsp_ready.
    - Then →IDLE.
    - A new command can be accepted no earlier than the cycle after the response handshake.
- Byte rules:
  - Source byte = cmd_src_hl ? rdata[15:8] : rdata[7:0].
  - For LOAD_IMM with size=0, the source byte is imm[7:0].
  - 8-bit write: data={8'h00, byte}, size=0, select_high_low=cmd_dst_hl, select_data_h_reg=cmd_dst_hl.
  - 16-bit write: data=full word, size=1, select_high_low=0, select_data_h_reg=0.
  - Size mixing is not permitted: MOVE uses cmd_size for both source and destination.
- Illegal commands (rsp_err=1, rsp_data=0):
  - cmd_op=3.
  - size=0 with dst≥BYTE_REGS (LOAD_IMM/MOVE).
  - size=0 with src≥BYTE_REGS (MOVE/READ).
- rsp_data:
  - READ: the word read (16-bit) or zero-extended byte (8-bit).
  - LOAD_IMM/MOVE: the value placed on data.
- Latency from accept to rsp_valid:
  - LOAD_IMM: 2 cycles.
  - READ: RD_LAT+1 cycles.
  - MOVE: RD_LAT+2 cycles.
- Bank outputs are registered. Outside RD_WAIT/WRITE, read_write=0 and select_reg keeps its last value.
- MOVE with src==dst is legal: perform the read, then the write.

Optional Feature:
- Macro: BANCO_CTRL_WRITE_CHECK_EN.
- When defined:
  - After WRITE, a CHECK state re-reads dst for RD_LAT cycles and compares it with the expected word or byte.
  - A mismatch sets rsp_err=1; rsp_data still holds the written value.
  - Write-command latency increases by RD_LAT+1.
- When undefined: no CHECK state; the latencies above apply.

Decomposition:
- Package banco_ctrl_pkg holds:
  - op_e (LOAD_IMM, MOVE, READ, RSVD).
  - state_e.
  - Constants READ=1'b0, WRITE=1'b1, SIZE8=0, SIZE16=1.
- Sub-module banco_ctrl_lat_cnt: a load/decrement counter that signals RD_LAT expiry. It is reused by RD_WAIT and CHECK.

Test Plan:
- LOAD_IMM dst=2, size=1, imm=16'hBEEF → one write cycle with select_reg=2, data=BEEF; rsp_data=BEEF 2 cycles after accept; a subsequent READ src=2 returns BEEF.
- LOAD_IMM dst=1, size=0, dst_hl=1, imm=16'h12A5 → write with data=00A5, select_high_low=1, select_data_h_reg=1; READ 8-bit src=1, src_hl=1 returns 00A5.
- MOVE size=0, src=0, src_hl=1, dst=3, dst_hl=0, with reg0=16'h7F01 → write data=007F to reg3 low; rsp_valid at accept+RD_LAT+2.
- LOAD_IMM size=0, dst=5 → rsp_err=1, rsp_data=0, read_write never asserted; cmd_op=3 behaves the same.
- rsp_ready held low for 5 cycles → rsp_valid/rsp_data stable and cmd_ready=0 throughout; a command offered then is accepted only after the handshake.
- reset deasserted→asserted during RD_WAIT of a MOVE → all outputs 0 asynchronously, cmd_ready=1 after release, no bank write observed.
